// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive and transmit paths.
//   UART_CLKS_PER_BIT : sysclk cycles per serial bit (9600 baud at 50 MHz).
//                       The transmit-side baud generator takes its bit period
//                       from this same constant, so both directions agree.
//   UART_DATA_W       : payload width of one frame.
//   uart_state_t      : receiver frame-tracking states.
//   is_busy_state     : true while a frame is actively being received.

package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 5208;
    localparam int UART_DATA_W       = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    // BREAK is deliberately excluded: the frame is over (and already reported
    // as a framing error) while the receiver just waits for the line to rise.
    function automatic logic is_busy_state(input logic [2:0] state);
        return (state == START) || (state == DATA) || (state == STOP);
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2
// Generic two-flop synchronizer for a single asynchronous input bit.
// Used for the UART rx pin as well as switches and buttons.
// Ports:
//   clk   : destination clock
//   reset : synchronous, active-high; both flops load RESET_VALUE
//   d     : asynchronous input
//   q     : synchronized output, two clk edges behind d
// Parameters:
//   RESET_VALUE : value both flops take in reset (idle level of the input)

module sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; the second gives it a full cycle to
    // resolve before anything downstream looks at the value.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
// 8N1 UART receive path: recovers frames of 1 start bit, 8 data bits
// (LSB first) and 1 stop bit from the asynchronous rx line, and presents each
// good byte with a one-cycle valid strobe.
// Ports:
//   sysclk      : system clock, all logic on its rising edge
//   reset       : synchronous, active-high
//   rx          : asynchronous serial line, idle high
//   rx_data     : last correctly framed byte; holds until the next good frame
//   rx_valid    : one-cycle pulse, rx_data was just updated
//   frame_error : one-cycle pulse, stop bit was sampled low
//   rx_busy     : high while a frame is in START, DATA or STOP
// Parameters:
//   CLKS_PER_BIT : sysclk cycles per bit, must be at least 4
//
// There is no consumer handshake: a byte whose rx_valid is missed is lost.
// Overrun detection lives in the register wrapper, not here.

module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   frame_error,
    output logic                   rx_busy
);

    // Timing constants. The start bit is checked half a bit after the edge so
    // that every later sample lands in the middle of its bit.
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [2:0]       IDX_LAST      = 3'(UART_DATA_W - 1);

    // Frame-tracking states, fixed encodings taken from the shared enum.
    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_START = START;
    localparam logic [2:0] S_DATA  = DATA;
    localparam logic [2:0] S_STOP  = STOP;
    localparam logic [2:0] S_BREAK = BREAK;

    logic                   rx_s;
    logic [2:0]             state;
    logic [2:0]             state_next;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             idx;
    logic [UART_DATA_W-1:0] sh;
    logic [1:0]             flush;
    logic                   armed;
    logic                   half_end;
    logic                   bit_end;

    // Bring the pin into the sysclk domain; idle-high reset value so a
    // freshly reset receiver does not see a phantom start bit.
    sync2 #(
        .RESET_VALUE(1'b1)
    ) u_rx_sync (
        .clk  (sysclk),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    assign half_end = (cnt == CNT_HALF_LAST);
    assign bit_end  = (cnt == CNT_BIT_LAST);

    // Next-state decode. Kept separate so rx_busy can be registered from it
    // and therefore track the state register exactly.
    //
    // IDLE only accepts a start bit once the receiver is armed: after reset
    // it must first see the line high. Without this, a reset in the middle
    // of a low data bit would make the synchronizer's 1->0 flush look like a
    // start edge and the tail of the aborted frame would be received as junk.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (armed && !rx_s) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (half_end) begin
                    state_next = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (idx == IDX_LAST)) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_next = rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Arming logic. flush marks when the synchronizer has shifted out its
    // reset value (two edges), after which rx_s reflects the real pin. Only
    // a genuine high on the line arms the receiver.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            flush <= 2'b00;
            armed <= 1'b0;
        end else begin
            flush <= {flush[0], 1'b1};
            if (flush[1] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    // State, bit timing counter, bit index and shift register. Data enters
    // at the MSB and shifts right, so after eight LSB-first bits the first
    // received bit sits in bit 0.
    //
    // Returning to IDLE at the stop-bit midpoint (rather than at its end)
    // lets a start edge that follows immediately be caught, so back-to-back
    // frames need no idle gap.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= 3'd0;
            sh    <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_START: begin
                    if (half_end) begin
                        cnt <= '0;
                        idx <= 3'd0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        sh  <= {rx_s, sh[UART_DATA_W-1:1]};
                        if (idx != IDX_LAST) begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Output registers. The strobes default low every cycle so each pulse is
    // exactly one cycle wide; they are set in mutually exclusive branches of
    // the stop-bit decision, so they can never be high together. A bad stop
    // bit leaves rx_data holding the last good byte.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            rx_busy     <= is_busy_state(state_next);
            if ((state == S_STOP) && bit_end) begin
                if (rx_s) begin
                    rx_data  <= sh;
                    rx_valid <= 1'b1;
                end else begin
                    frame_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
// Self-checking bench for uart_receiver with an 16-cycle bit period.
// A frame-level model predicts, from the time each frame's falling edge is
// driven, when rx_busy is high, when rx_valid/frame_error pulse and what
// rx_data holds; a compare process checks all four outputs every cycle.
// Directed scenarios add literal expectations on pulse counts, data, spacing
// and latency.

module tb_uart_receiver;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    // Pin is driven just after edge n0; two synchronizer edges later rx_s is
    // low, and the receiver sees it on the third edge.
    localparam int SYNC_LAT = 3;
    localparam int STOP_OFS = SYNC_LAT + HALF + 9 * CPB;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic       rx     = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       rx_busy;

    int error_count = 0;
    int check_count = 0;
    int cyc = 0;

    // Frame model: one outstanding frame at a time.
    bit         frame_active = 1'b0;
    int         busy_start   = 0;
    int         busy_end     = -1;
    int         ev_cycle     = -1;
    bit         ev_is_err    = 1'b0;
    logic [7:0] ev_data      = 8'h00;
    int         reset_cycle  = -1;
    logic [7:0] model_data   = 8'h00;
    int         last_start   = 0;

    logic exp_valid;
    logic exp_err;
    logic exp_busy;

    int         valid_cycles[$];
    logic [7:0] valid_bytes[$];
    int         err_cycles[$];
    logic [7:0] err_bytes[$];
    int         busy_total = 0;

    uart_receiver #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_error(frame_error),
        .rx_busy    (rx_busy)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Hold rx at a level for a number of clock cycles.
    task automatic applyStimulus(input logic level, input int cycles);
        rx = level;
        repeat (cycles) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    // Drive one full frame and register its expected outcome with the model.
    // reset_bit selects a bit position (0=start, 1..8=data, 9=stop) during
    // which a one-cycle reset pulse is applied; -1 for none.
    task automatic sendFrame(input logic [7:0] data, input logic stop_bit,
                             input int reset_bit);
        int   n0;
        logic b;
        n0           = cyc;
        last_start   = n0;
        busy_start   = n0 + SYNC_LAT;
        busy_end     = n0 + STOP_OFS - 1;
        ev_cycle     = n0 + STOP_OFS;
        ev_is_err    = !stop_bit;
        ev_data      = data;
        frame_active = 1'b1;
        for (int pos = 0; pos < 10; pos++) begin
            if (pos == 0)      b = 1'b0;
            else if (pos == 9) b = stop_bit;
            else               b = data[pos-1];
            rx = b;
            for (int c = 0; c < CPB; c++) begin
                if (pos == reset_bit && c == HALF / 2) begin
                    reset       = 1'b1;
                    reset_cycle = cyc + 1;
                end
                if (pos == reset_bit && c == HALF / 2 + 1) begin
                    reset = 1'b0;
                end
                @(posedge sysclk);
                #1;
            end
        end
    endtask

    // Per-cycle comparison against the frame model.
    always @(negedge sysclk) begin
        if (cyc == reset_cycle) begin
            frame_active = 1'b0;
            model_data   = 8'h00;
        end
        exp_valid = frame_active && (cyc == ev_cycle) && !ev_is_err;
        exp_err   = frame_active && (cyc == ev_cycle) && ev_is_err;
        exp_busy  = frame_active && (cyc >= busy_start) && (cyc <= busy_end);
        if (exp_valid) model_data = ev_data;
        checkOutput("rx_valid", {31'd0, rx_valid}, {31'd0, exp_valid});
        checkOutput("frame_error", {31'd0, frame_error}, {31'd0, exp_err});
        checkOutput("rx_busy", {31'd0, rx_busy}, {31'd0, exp_busy});
        checkOutput("rx_data", {24'd0, rx_data}, {24'd0, model_data});
        if (rx_valid) begin
            valid_cycles.push_back(cyc);
            valid_bytes.push_back(rx_data);
        end
        if (frame_error) begin
            err_cycles.push_back(cyc);
            err_bytes.push_back(rx_data);
        end
        if (rx_busy) busy_total++;
    end

    initial begin
        int v0;
        int e0;
        int b0;

        // Reset state
        repeat (2) begin
            @(posedge sysclk);
            #1;
        end
        checkOutput("reset_rx_data", {24'd0, rx_data}, 32'h00);
        checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("reset_frame_error", {31'd0, frame_error}, 32'd0);
        checkOutput("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        repeat (2) begin
            @(posedge sysclk);
            #1;
        end
        reset = 1'b0;
        applyStimulus(1'b1, 10);

        // Single good frame 0xA5
        $display("[TB] frame 0xA5");
        v0 = valid_cycles.size();
        e0 = err_cycles.size();
        b0 = busy_total;
        sendFrame(8'hA5, 1'b1, -1);
        applyStimulus(1'b1, 20);
        checkOutput("a5_pulses", valid_cycles.size() - v0, 32'd1);
        checkOutput("a5_data", {24'd0, rx_data}, 32'hA5);
        checkOutput("a5_no_err", err_cycles.size() - e0, 32'd0);
        checkOutput("a5_busy_cycles", busy_total - b0, 32'd152);

        // Back-to-back 0x00 then 0xFF
        $display("[TB] back-to-back 0x00 0xFF");
        v0 = valid_cycles.size();
        sendFrame(8'h00, 1'b1, -1);
        sendFrame(8'hFF, 1'b1, -1);
        applyStimulus(1'b1, 20);
        checkOutput("b2b_pulses", valid_cycles.size() - v0, 32'd2);
        if (valid_cycles.size() >= v0 + 2) begin
            checkOutput("b2b_gap", valid_cycles[v0+1] - valid_cycles[v0], 32'd160);
            checkOutput("b2b_first", {24'd0, valid_bytes[v0]}, 32'h00);
            checkOutput("b2b_second", {24'd0, valid_bytes[v0+1]}, 32'hFF);
        end

        // 3-cycle glitch on idle line
        $display("[TB] glitch");
        v0           = valid_cycles.size();
        e0           = err_cycles.size();
        b0           = busy_total;
        busy_start   = cyc + SYNC_LAT;
        busy_end     = cyc + SYNC_LAT + HALF - 1;
        ev_cycle     = -1;
        frame_active = 1'b1;
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 30);
        checkOutput("glitch_busy_cycles", busy_total - b0, 32'd8);
        checkOutput("glitch_no_valid", valid_cycles.size() - v0, 32'd0);
        checkOutput("glitch_no_err", err_cycles.size() - e0, 32'd0);

        // Framing error 0x3C, held-low line, recovery with 0x5A
        $display("[TB] framing error then break");
        v0 = valid_cycles.size();
        e0 = err_cycles.size();
        sendFrame(8'h3C, 1'b0, -1);
        b0 = busy_total;
        applyStimulus(1'b0, 40);
        checkOutput("break_no_busy", busy_total - b0, 32'd0);
        checkOutput("break_err_pulses", err_cycles.size() - e0, 32'd1);
        checkOutput("break_err_data", {24'd0, err_bytes[$]}, 32'hFF);
        checkOutput("break_no_valid", valid_cycles.size() - v0, 32'd0);
        applyStimulus(1'b1, 20);
        sendFrame(8'h5A, 1'b1, -1);
        applyStimulus(1'b1, 20);
        checkOutput("recover_pulses", valid_cycles.size() - v0, 32'd1);
        checkOutput("recover_data", {24'd0, rx_data}, 32'h5A);

        // Reset during data bit 4 of 0x81
        $display("[TB] reset mid-frame");
        v0 = valid_cycles.size();
        e0 = err_cycles.size();
        sendFrame(8'h81, 1'b1, 5);
        applyStimulus(1'b1, 20);
        checkOutput("rst_no_valid", valid_cycles.size() - v0, 32'd0);
        checkOutput("rst_no_err", err_cycles.size() - e0, 32'd0);
        checkOutput("rst_rx_data", {24'd0, rx_data}, 32'h00);
        checkOutput("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
        sendFrame(8'h42, 1'b1, -1);
        applyStimulus(1'b1, 20);
        checkOutput("after_rst_pulses", valid_cycles.size() - v0, 32'd1);
        checkOutput("after_rst_data", {24'd0, rx_data}, 32'h42);

        // Pin-to-valid latency with a random start phase
        $display("[TB] latency");
        v0 = valid_cycles.size();
        applyStimulus(1'b1, $urandom_range(0, 2));
        sendFrame(8'hA5, 1'b1, -1);
        applyStimulus(1'b1, 20);
        checkOutput("lat_pulses", valid_cycles.size() - v0, 32'd1);
        if (valid_cycles.size() > v0) begin
            checkOutput("lat_cycles", valid_cycles[$] - last_start, 32'd155);
        end

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
